sdp_sram_init: RTL and testbench

- Parametrised simple dual-port synchronous SRAM; generational successor to the team's 16x8 single-port asynchronous-read SRAM.
- Adds:
  - independent read and write ports;
  - registered reads with configurable latency and a valid strobe;
  - per-byte write enables;
  - selectable read/write collision mode;
  - hardware zero-initialisation sweep after reset.
- Used as the general scratch/buffer memory under FIFOs and packet buffers.

---
 rtl/sdp_sram_init.sv | 166 ++++++++++++++++
 tb/tb_sdp_sram_init.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_sram_init.sv
// sdp_sram_init: parametrised simple dual-port synchronous SRAM with a
// hardware zero-initialisation sweep after reset.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous active-high reset
//   wr_en      write request
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte enables, bit i covers wr_data[8i+7:8i]
//   rd_en      read request
//   rd_addr    read address
//   rd_data    registered read data, holds when no read completes
//   rd_valid   one-cycle strobe per completed read
//   init_busy  high while the zero-initialisation sweep runs
//
// Reads complete READ_LATENCY (1 or 2) edges after sampling. Out-of-range
// writes are dropped and out-of-range reads return zero. WRITE_FIRST selects
// whether a same-address read/write collision returns the old or merged word.

module sdp_sram_init #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int NB = DATA_WIDTH / 8;
    // Counter and range compares are one bit wider than the address so that
    // DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // Post-write word: enabled lanes from wr_data, the rest from the array.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if ((WRITE_FIRST != 0) && wr_en && wr_in_range && (wr_addr == rd_addr)) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    // FSM next state and array write port selection
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_we     = 1'b0;
        mem_wa     = wr_addr;
        mem_wd     = wr_merged;
        rd_fire    = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_wa     = init_cnt_q[ADDR_WIDTH-1:0];
                mem_wd     = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_W) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we  = wr_en && wr_in_range;
                rd_fire = rd_en;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Read pipeline: the first stage captures the word at the sampling edge;
    // with latency 2 the output stage takes it one edge later. Output data
    // only moves when a result arrives so it holds otherwise.
    always_comb begin
        s1_valid_d = rd_fire;
        s1_data_d  = rd_fire ? rd_word : s1_data_q;
        if (READ_LATENCY == 2) begin
            rd_valid_d = s1_valid_q;
            rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
        end else begin
            rd_valid_d = rd_fire;
            rd_data_d  = rd_fire ? rd_word : rd_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Array contents are not reset; the sweep clears them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_sdp_sram_init.sv
// Bench for sdp_sram_init: two instances sharing one stimulus stream,
//   inst 0: 16-bit, DEPTH=12, READ_LATENCY=1, read-first
//   inst 1: 16-bit, DEPTH=16, READ_LATENCY=2, write-first
// A behavioural memory model with a delay ring predicts every output each
// cycle; literal checks pin the model on the hand-computed scenarios.

module tb_sdp_sram_init;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [15:0] o_data [2];
    logic        o_valid [2];
    logic        o_busy [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_sram_init #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(1), .WRITE_FIRST(0)
    ) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_data[0]),
        .rd_valid(o_valid[0]), .init_busy(o_busy[0])
    );

    sdp_sram_init #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2), .WRITE_FIRST(1)
    ) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_data[1]),
        .rd_valid(o_valid[1]), .init_busy(o_busy[1])
    );

    // ---------------- behavioural model ----------------
    int          DEP [2] = '{12, 16};
    int          LAT [2] = '{1, 2};
    int          WF  [2] = '{0, 1};
    logic [15:0] m_mem [2][16];
    int          m_init [2];
    logic        m_valid [2];
    logic [15:0] m_data [2];
    logic        slot_v [2][4];
    logic [15:0] slot_d [2][4];
    int          m_cycle = 0;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] be);
        merge = {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_init[i]  = 0;
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
                for (int s = 0; s < 4; s++) slot_v[i][s] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_init[i] < DEP[i]) begin
                    m_mem[i][m_init[i]] = '0;
                    m_init[i]++;
                end else begin
                    if (rd_en) begin
                        logic [15:0] rv;
                        if (int'(rd_addr) >= DEP[i]) rv = '0;
                        else if (WF[i] == 1 && wr_en && wr_addr == rd_addr)
                            rv = merge(m_mem[i][rd_addr], wr_data, wr_be);
                        else rv = m_mem[i][rd_addr];
                        slot_v[i][(m_cycle + LAT[i] - 1) % 4] = 1'b1;
                        slot_d[i][(m_cycle + LAT[i] - 1) % 4] = rv;
                    end
                    if (wr_en && int'(wr_addr) < DEP[i])
                        m_mem[i][wr_addr] = merge(m_mem[i][wr_addr], wr_data, wr_be);
                end
                m_valid[i] = slot_v[i][m_cycle % 4];
                if (m_valid[i]) begin
                    m_data[i] = slot_d[i][m_cycle % 4];
                    slot_v[i][m_cycle % 4] = 1'b0;
                end
            end
            m_cycle++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_valid[%0d]", i), 32'(o_valid[i]), 32'(m_valid[i]));
            chk($sformatf("model_data[%0d]", i), 32'(o_data[i]), 32'(m_data[i]));
            chk($sformatf("model_busy[%0d]", i), 32'(o_busy[i]), 32'(m_init[i] < DEP[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input logic re, input logic [3:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    endtask

    // Count edges until each instance leaves INIT, reading all the while.
    task automatic wait_init(input string tag);
        int n = 0;
        int fa = 0;
        while (o_busy[1] && n < 200) begin
            step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'($urandom_range(0, 15)));
            n++;
            if (!o_busy[0] && fa == 0) fa = n;
        end
        chk({tag, "_fall_b"}, 32'(n), 32'd16);
        chk({tag, "_fall_a"}, 32'(fa), 32'd12);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(o_busy[i]), 32'd1);
            chk("rst_valid", 32'(o_valid[i]), 32'd0);
            chk("rst_data", 32'(o_data[i]), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1'b1, 4'd1, 16'hFFFF, 2'b11, 1'b1, 4'd1);
        reset = 1'b0;
        wait_init("init1");

        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
        idle(); idle();

        // random fill then read back
        for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 16'($urandom), 2'b11, 1'b0, 4'd0);
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
        idle(); idle();

        // byte enables
        step(1'b1, 4'd3, 16'hAABB, 2'b11, 1'b0, 4'd0);
        step(1'b1, 4'd3, 16'h1122, 2'b01, 1'b0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        chk("be_a", 32'(o_data[0]), 32'h0000AA22);
        idle();
        chk("be_b", 32'(o_data[1]), 32'h0000AA22);
        step(1'b1, 4'd3, 16'h5555, 2'b00, 1'b0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        chk("be0_a", 32'(o_data[0]), 32'h0000AA22);
        idle();
        chk("be0_b", 32'(o_data[1]), 32'h0000AA22);

        // collision
        step(1'b1, 4'd5, 16'h003C, 2'b11, 1'b0, 4'd0);
        step(1'b1, 4'd5, 16'h00C3, 2'b11, 1'b1, 4'd5);
        chk("coll_rf_a", 32'(o_data[0]), 32'h0000003C);
        idle();
        chk("coll_wf_b", 32'(o_data[1]), 32'h000000C3);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        chk("after_coll_a", 32'(o_data[0]), 32'h000000C3);
        idle();
        chk("after_coll_b", 32'(o_data[1]), 32'h000000C3);

        // latency 2 back-to-back
        step(1'b1, 4'd1, 16'h1111, 2'b11, 1'b0, 4'd0);
        step(1'b1, 4'd2, 16'h2222, 2'b11, 1'b0, 4'd0);
        step(1'b1, 4'd3, 16'h3333, 2'b11, 1'b0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1);
        chk("lat2_v0", 32'(o_valid[1]), 32'd0);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
        chk("lat2_v1", 32'(o_valid[1]), 32'd1);
        chk("lat2_d1", 32'(o_data[1]), 32'h00001111);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        chk("lat2_v2", 32'(o_valid[1]), 32'd1);
        chk("lat2_d2", 32'(o_data[1]), 32'h00002222);
        idle();
        chk("lat2_v3", 32'(o_valid[1]), 32'd1);
        chk("lat2_d3", 32'(o_data[1]), 32'h00003333);
        idle();
        chk("lat2_v4", 32'(o_valid[1]), 32'd0);

        // out-of-range on the DEPTH=12 instance
        step(1'b1, 4'd14, 16'hBEEF, 2'b11, 1'b0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd14);
        chk("oor_a_valid", 32'(o_valid[0]), 32'd1);
        chk("oor_a_data", 32'(o_data[0]), 32'd0);
        idle();
        chk("inr_b_data", 32'(o_data[1]), 32'h0000BEEF);

        // random mixed traffic with frequent collisions
        for (int k = 0; k < 400; k++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15)));
        end
        idle(); idle();

        // reset between the sampling edge and the output edge
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_valid_b", 32'(o_valid[1]), 32'd0);
        chk("midrst_data_b", 32'(o_data[1]), 32'd0);
        chk("midrst_busy_b", 32'(o_busy[1]), 32'd1);
        chk("midrst_busy_a", 32'(o_busy[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("midrst_drop_b", 32'(o_valid[1]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("init2");
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
        idle(); idle();
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        chk("swept_a_valid", 32'(o_valid[0]), 32'd1);
        chk("swept_a_data", 32'(o_data[0]), 32'd0);
        idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
